// File: rtl/sync_handshake_tx.sv
// Source side of a two-phase (toggle) req/ack clock-domain crossing.
// Holds each value stable on xfer_data, toggles xfer_req to announce it, and
// waits for the far end's synchronized ack toggle before launching the next.
// Values offered mid-transfer are coalesced into a one-entry pending slot.
module sync_handshake_tx #(
    parameter int unsigned width    = 8,
    parameter int unsigned cntwidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [width-1:0]    din,
    input  logic                din_valid,
    output logic                busy,
    output logic [width-1:0]    xfer_data,
    output logic                xfer_req,
    input  logic                xfer_ack,
    output logic [cntwidth-1:0] overwrite_cnt,
    output logic                proto_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic               ack_s1, ack_s2;
    logic               done;
    logic               pending_valid, pending_valid_next;
    logic [width-1:0]   pending_data, pending_data_next;
    logic [width-1:0]   xfer_data_next;
    logic               xfer_req_next;
    logic               proto_err_next;
    logic               cnt_inc;

    assign done = (ack_s2 == xfer_req);

    // Two-flop synchronizer for the asynchronous ack toggle
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= xfer_ack;
            ack_s2 <= ack_s1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state and datapath update decisions
    always_comb begin
        state_next         = state;
        xfer_data_next     = xfer_data;
        xfer_req_next      = xfer_req;
        pending_valid_next = pending_valid;
        pending_data_next  = pending_data;
        proto_err_next     = proto_err;
        cnt_inc            = 1'b0;
        unique case (state)
            IDLE: begin
                if (ack_s2 != xfer_req) proto_err_next = 1'b1;
                if (din_valid) begin
                    xfer_data_next = din;
                    xfer_req_next  = ~xfer_req;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (!done) begin
                    if (din_valid) begin
                        pending_data_next  = din;
                        pending_valid_next = 1'b1;
                        cnt_inc            = pending_valid;
                    end
                end else if (din_valid) begin
                    // Fresh input beats the pending slot; the old pending value is dropped
                    xfer_data_next     = din;
                    xfer_req_next      = ~xfer_req;
                    pending_valid_next = 1'b0;
                    cnt_inc            = pending_valid;
                end else if (pending_valid) begin
                    xfer_data_next     = pending_data;
                    xfer_req_next      = ~xfer_req;
                    pending_valid_next = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered datapath, pending slot, counters and sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            xfer_data     <= '0;
            xfer_req      <= 1'b0;
            pending_valid <= 1'b0;
            pending_data  <= '0;
            overwrite_cnt <= '0;
            proto_err     <= 1'b0;
        end else begin
            xfer_data     <= xfer_data_next;
            xfer_req      <= xfer_req_next;
            pending_valid <= pending_valid_next;
            pending_data  <= pending_data_next;
            proto_err     <= proto_err_next;
            if (cnt_inc && (overwrite_cnt != '1))
                overwrite_cnt <= overwrite_cnt + cntwidth'(1);
        end
    end

    // Output decode: busy mirrors the WAIT state
    always_comb begin
        busy = (state == WAIT);
    end

endmodule

// File: tb/tb_sync_handshake_tx.sv
// Directed bench for sync_handshake_tx; the far end is modelled by driving
// xfer_ack by hand. Uses a 2-bit counter so saturation is reachable.
module tb_sync_handshake_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       busy;
    logic [7:0] xfer_data;
    logic       xfer_req;
    logic       xfer_ack;
    logic [1:0] overwrite_cnt;
    logic       proto_err;

    int n_assert = 0;
    int n_fail   = 0;

    sync_handshake_tx #(.width(8), .cntwidth(2)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .busy(busy),
        .xfer_data(xfer_data),
        .xfer_req(xfer_req),
        .xfer_ack(xfer_ack),
        .overwrite_cnt(overwrite_cnt),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0; din = '0; din_valid = 1'b0; xfer_ack = 1'b0;

        // Reset
        ticks(2);
        chk("rst_req",  32'(xfer_req), 0);
        chk("rst_data", 32'(xfer_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt",  32'(overwrite_cnt), 0);
        chk("rst_perr", 32'(proto_err), 0);

        // First send from IDLE
        rst = 1'b1; din = 8'h5A; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("send_data", 32'(xfer_data), 'h5A);
        chk("send_req",  32'(xfer_req), 1);
        chk("send_busy", 32'(busy), 1);

        // Ack three cycles after the req toggle
        ticks(2);
        chk("wait_busy", 32'(busy), 1);
        xfer_ack = 1'b1;
        tick();
        chk("ack_m0_busy", 32'(busy), 1);
        tick();
        chk("ack_m1_busy", 32'(busy), 1);
        chk("ack_m1_data", 32'(xfer_data), 'h5A);
        tick();
        chk("ack_m2_busy", 32'(busy), 0);
        chk("ack_m2_data", 32'(xfer_data), 'h5A);
        chk("ack_m2_perr", 32'(proto_err), 0);

        // Coalescing: A0 in flight, then 11, 22, 33 offered
        din = 8'hA0; din_valid = 1'b1;
        tick();
        chk("co_req", 32'(xfer_req), 0);
        din = 8'h11; tick();
        din = 8'h22; tick();
        din = 8'h33; tick();
        din_valid = 1'b0;
        chk("co_cnt",  32'(overwrite_cnt), 2);
        chk("co_hold", 32'(xfer_data), 'hA0);
        xfer_ack = 1'b0;
        ticks(2);
        chk("co_m1_data", 32'(xfer_data), 'hA0);
        tick();
        chk("co_launch_data", 32'(xfer_data), 'h33);
        chk("co_launch_req",  32'(xfer_req), 1);
        chk("co_launch_busy", 32'(busy), 1);
        xfer_ack = 1'b1;
        ticks(2);
        chk("co2_m1_busy", 32'(busy), 1);
        tick();
        chk("co2_idle", 32'(busy), 0);

        // Completion collision: pending 44, fresh 55 on completion edge
        din = 8'h60; din_valid = 1'b1;
        tick();
        din = 8'h44; tick();
        din_valid = 1'b0;
        xfer_ack = 1'b0;
        ticks(2);
        din = 8'h55; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("col_data", 32'(xfer_data), 'h55);
        chk("col_req",  32'(xfer_req), 1);
        chk("col_cnt",  32'(overwrite_cnt), 3);
        xfer_ack = 1'b1;
        ticks(3);
        chk("col_idle", 32'(busy), 0);
        chk("col_final_data", 32'(xfer_data), 'h55);

        // Saturation from a cleared counter
        rst = 1'b0; xfer_ack = 1'b0;
        tick();
        rst = 1'b1;
        chk("sat_rst_cnt", 32'(overwrite_cnt), 0);
        din = 8'h70; din_valid = 1'b1;
        tick();
        chk("sat_req", 32'(xfer_req), 1);
        din = 8'h01; tick();
        din = 8'h02; tick();
        din = 8'h03; tick();
        chk("sat_cnt2", 32'(overwrite_cnt), 2);
        din = 8'h04; tick();
        chk("sat_cnt3", 32'(overwrite_cnt), 3);
        din = 8'h05; tick();
        din = 8'h06; tick();
        din_valid = 1'b0;
        chk("sat_hold", 32'(overwrite_cnt), 3);
        xfer_ack = 1'b1;
        ticks(3);
        chk("sat_launch_data", 32'(xfer_data), 'h06);
        chk("sat_launch_req",  32'(xfer_req), 0);
        xfer_ack = 1'b0;
        ticks(3);
        chk("sat_idle", 32'(busy), 0);

        // Protocol error: ack toggles while IDLE
        xfer_ack = 1'b1;
        ticks(2);
        chk("perr_m1", 32'(proto_err), 0);
        tick();
        chk("perr_set", 32'(proto_err), 1);
        chk("perr_busy", 32'(busy), 0);
        xfer_ack = 1'b0;
        ticks(3);
        chk("perr_sticky", 32'(proto_err), 1);

        // Reset mid-transfer with pending data
        din = 8'h88; din_valid = 1'b1;
        tick();
        din = 8'h99; tick();
        din_valid = 1'b0;
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b0;
        tick();
        chk("mid_rst_req",  32'(xfer_req), 0);
        chk("mid_rst_data", 32'(xfer_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cnt",  32'(overwrite_cnt), 0);
        chk("mid_rst_perr", 32'(proto_err), 0);
        rst = 1'b1;
        tick();
        din = 8'h77; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("post_req",  32'(xfer_req), 1);
        chk("post_data", 32'(xfer_data), 'h77);
        xfer_ack = 1'b1;
        ticks(3);
        chk("post_idle", 32'(busy), 0);
        chk("post_data_final", 32'(xfer_data), 'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
